// File: rtl/ledr_pwm_driver.sv
// ledr_pwm_driver
//   Sits between the LEDR PIO out_port and the board LEDR pins. Applies a
//   global 8-bit PWM brightness and an optional blink gate to the pattern
//   written by the CPU. Control lives on a small Avalon-MM slave.
//
// Ports
//   clk         system clock
//   reset_n     asynchronous active-low reset
//   led_in      LED pattern from the upstream PIO
//   address     register select (0 CTRL, 1 DUTY, 2 HALF_PERIOD, 3 STATUS)
//   chipselect  slave select
//   write_n     write strobe, active-low
//   writedata   write data
//   readdata    combinational, zero-wait read data
//   led_out     registered LED drive
module ledr_pwm_driver #(
   parameter int LED_WIDTH = 10,
   parameter int PRESCALE  = 50000
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic [LED_WIDTH-1:0] led_in,
   input  logic [1:0]           address,
   input  logic                 chipselect,
   input  logic                 write_n,
   input  logic [31:0]          writedata,
   output logic [31:0]          readdata,
   output logic [LED_WIDTH-1:0] led_out
);

   localparam int              PRE_W   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(PRESCALE - 1);

   logic [1:0]       ctrl_q;
   logic [7:0]       duty_q;
   logic [7:0]       duty_act_q;
   logic [15:0]      half_q;
   logic [7:0]       pwm_cnt_q;
   logic [PRE_W-1:0] pre_q;
   logic [15:0]      blink_cnt_q;
   logic             phase_q;

   logic wr_en, wr_ctrl, wr_duty, wr_half;
   logic tick, blink_hold, pwm_on;
   logic unused_wdata;

   assign wr_en   = chipselect & ~write_n;
   assign wr_ctrl = wr_en & (address == 2'd0);
   assign wr_duty = wr_en & (address == 2'd1);
   assign wr_half = wr_en & (address == 2'd2);

   assign tick   = (pre_q == PRE_MAX);
   assign pwm_on = (duty_act_q == 8'hFF) | (pwm_cnt_q < duty_act_q);

   // A CTRL write clearing blink_en parks the blinker on the same edge the
   // register updates, so phase is 1 from the very next clock.
   assign blink_hold = (wr_ctrl & ~writedata[1]) | ~ctrl_q[1] | (half_q == 16'd0);

   assign unused_wdata = ^writedata[31:16];

   // Registers written over Avalon
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ctrl_q <= 2'b00;
         duty_q <= 8'hFF;
         half_q <= 16'd500;
      end else begin
         if (wr_ctrl) ctrl_q <= writedata[1:0];
         if (wr_duty) duty_q <= writedata[7:0];
         if (wr_half) half_q <= writedata[15:0];
      end
   end

   // PWM counter; duty is sampled only at the wrap so a window never mixes
   // two duty values. duty_q is the pre-write value on a coincident write.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pwm_cnt_q  <= 8'd0;
         duty_act_q <= 8'hFF;
      end else begin
         pwm_cnt_q <= pwm_cnt_q + 8'd1;
         if (pwm_cnt_q == 8'hFF) duty_act_q <= duty_q;
      end
   end

   // Blink tick prescaler, free-running
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) pre_q <= '0;
      else if (tick) pre_q <= '0;
      else           pre_q <= pre_q + PRE_W'(1);
   end

   // Blink phase. A HALF_PERIOD write restarts the half-period and wins
   // over a tick landing in the same cycle.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         blink_cnt_q <= 16'd0;
         phase_q     <= 1'b1;
      end else if (wr_half || blink_hold) begin
         blink_cnt_q <= 16'd0;
         phase_q     <= 1'b1;
      end else if (tick) begin
         if (blink_cnt_q == half_q - 16'd1) begin
            blink_cnt_q <= 16'd0;
            phase_q     <= ~phase_q;
         end else begin
            blink_cnt_q <= blink_cnt_q + 16'd1;
         end
      end
   end

   // Output register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)       led_out <= '0;
      else if (ctrl_q[0]) led_out <= led_in & {LED_WIDTH{pwm_on & phase_q}};
      else                led_out <= led_in;
   end

   always_comb begin
      readdata = 32'd0;
      case (address)
         2'd0: readdata = {30'd0, ctrl_q};
         2'd1: readdata = {24'd0, duty_q};
         2'd2: readdata = {16'd0, half_q};
         2'd3: readdata = {16'd0, pwm_cnt_q, 7'd0, phase_q};
         default: readdata = 32'd0;
      endcase
   end

endmodule

// File: tb/tb_ledr_pwm_driver.sv
// Self-checking bench for ledr_pwm_driver: reset/read vector table, PWM
// window table, hand-written blink/reset corner sequences and a random
// phase checked every cycle against a tick-count reference model.
module tb_ledr_pwm_driver;
   localparam int LW = 10;
   localparam int P  = 4;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic [LW-1:0] led_in = '0;
   logic [1:0]    address = 2'd0;
   logic          chipselect = 1'b0;
   logic          write_n = 1'b1;
   logic [31:0]   writedata = 32'd0;
   logic [31:0]   readdata;
   logic [LW-1:0] led_out;

   int n_checks = 0;
   int n_errors = 0;

   ledr_pwm_driver #(.LED_WIDTH(LW), .PRESCALE(P)) dut (
      .clk(clk), .reset_n(reset_n), .led_in(led_in), .address(address),
      .chipselect(chipselect), .write_n(write_n), .writedata(writedata),
      .readdata(readdata), .led_out(led_out));

   always #5 clk = ~clk;

   // Reference model: time since reset and ticks since last blink restart.
   int            m_cyc;
   int            m_ticks;
   logic [1:0]    m_ctrl;
   logic [7:0]    m_duty, m_dact;
   logic [15:0]   m_half;
   logic [LW-1:0] m_led;

   function automatic void model_reset();
      m_cyc = 0; m_ticks = 0; m_ctrl = 2'b00; m_duty = 8'hFF; m_dact = 8'hFF;
      m_half = 16'd500; m_led = '0;
   endfunction

   function automatic logic m_phase();
      if (m_half == 16'd0) return 1'b1;
      return ((m_ticks / int'(m_half)) % 2) == 0;
   endfunction

   function automatic logic [31:0] m_read(input logic [1:0] a);
      case (a)
         2'd0: return {30'd0, m_ctrl};
         2'd1: return {24'd0, m_duty};
         2'd2: return {16'd0, m_half};
         default: return {16'd0, 8'(m_cyc % 256), 7'd0, m_phase()};
      endcase
   endfunction

   function automatic void model_step();
      int   pwm = m_cyc % 256;
      logic on  = (m_dact == 8'hFF) || (pwm < int'(m_dact));
      logic wr  = chipselect && !write_n;
      logic tk  = (m_cyc % P) == P - 1;
      logic [LW-1:0] nxt = m_ctrl[0] ? (led_in & {LW{on & m_phase()}}) : led_in;
      if (wr && address == 2'd2)                       m_ticks = 0;
      else if (wr && address == 2'd0 && !writedata[1]) m_ticks = 0;
      else if (!m_ctrl[1] || m_half == 16'd0)          m_ticks = 0;
      else if (tk)                                     m_ticks++;
      if (pwm == 255) m_dact = m_duty;
      if (wr) begin
         case (address)
            2'd0: m_ctrl = writedata[1:0];
            2'd1: m_duty = writedata[7:0];
            2'd2: m_half = writedata[15:0];
            default: ;
         endcase
      end
      m_cyc++;
      m_led = nxt;
   endfunction

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h exp=%h at %0t", nm, got, exp, $time);
      end
   endtask

   task automatic step();
      model_step();
      @(posedge clk);
      #1;
      chk("model_led_out", 32'(led_out), 32'(m_led));
      chk("model_readdata", readdata, m_read(address));
   endtask

   task automatic wr_reg(input logic [1:0] a, input logic [31:0] d);
      address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
      step();
      chipselect = 1'b0; write_n = 1'b1; address = 2'd3;
      #1;
   endtask

   task automatic wait_pwm(input logic [7:0] v);
      int k = 0;
      while (readdata[15:8] != v && k < 300) begin step(); k++; end
      if (readdata[15:8] != v) chk("wait_pwm_timeout", 32'(readdata[15:8]), 32'(v));
   endtask

   // Call with STATUS showing pwm_cnt == 1: sample i reflects pwm_cnt i.
   task automatic window(input string nm, input logic [LW-1:0] pat, input int exp_on);
      int on = 0, bad = 0;
      for (int i = 0; i < 256; i++) begin
         if (led_out == pat) on++;
         if (led_out != ((i < exp_on) ? pat : '0)) bad++;
         step();
      end
      chk({nm, "_on_count"}, 32'(on), 32'(exp_on));
      chk({nm, "_shape_errs"}, 32'(bad), 32'd0);
   endtask

   typedef struct { logic [1:0] a; logic [31:0] exp; } rd_vec_t;
   typedef struct { logic [7:0] duty; logic [LW-1:0] pat; int on_cnt; int nwin; } pwm_vec_t;

   rd_vec_t  rv[4];
   pwm_vec_t pv[5];

   initial begin
      logic [LW-1:0] prev, v;
      logic          v_ph;
      int            k, len, bad;

      rv[0] = '{2'd0, 32'h0000_0000};
      rv[1] = '{2'd1, 32'h0000_00FF};
      rv[2] = '{2'd2, 32'h0000_01F4};
      rv[3] = '{2'd3, 32'h0000_0001};
      pv[0] = '{8'd64,  10'h155, 64,  4};
      pv[1] = '{8'd0,   10'h3FF, 0,   1};
      pv[2] = '{8'd255, 10'h2AA, 256, 1};
      pv[3] = '{8'd1,   10'h3FF, 1,   1};
      pv[4] = '{8'd200, 10'h0F0, 200, 1};

      // Reset, idle passthrough
      model_reset();
      led_in = 10'h3FF;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_led_out", 32'(led_out), 32'd0);
      foreach (rv[i]) begin
         address = rv[i].a; #1;
         chk("reset_read", readdata, rv[i].exp);
      end
      @(negedge clk);
      reset_n = 1'b1;
      address = 2'd3;
      step();
      chk("release_passthru", 32'(led_out), 32'h3FF);

      // PWM duty windows
      wr_reg(2'd0, 32'd1);
      foreach (pv[i]) begin
         led_in = pv[i].pat;
         wr_reg(2'd1, {24'd0, pv[i].duty});
         wait_pwm(8'd255);
         wait_pwm(8'd1);
         for (int w = 0; w < pv[i].nwin; w++) window("pwm_window", pv[i].pat, pv[i].on_cnt);
      end

      // DUTY write landing on pwm_cnt == 255 applies one window later
      led_in = 10'h3FF;
      wr_reg(2'd1, 32'd0);
      wait_pwm(8'd255);
      wait_pwm(8'd1);
      wait_pwm(8'd255);
      wr_reg(2'd1, 32'd255);
      step();
      window("late_duty_old", 10'h3FF, 0);
      window("late_duty_new", 10'h3FF, 256);

      // Blink: HALF_PERIOD 3 ticks x PRESCALE 4 -> 12-clock runs
      led_in = 10'h001;
      wr_reg(2'd0, 32'd3);
      wr_reg(2'd2, 32'd3);
      prev = led_out; k = 0;
      while (led_out == prev && k < 40) begin step(); k++; end
      for (int r = 0; r < 3; r++) begin
         v = led_out; len = 0;
         while (led_out == v && len < 40) begin step(); len++; end
         chk("blink_run_len", 32'(len), 32'd12);
      end
      v_ph = readdata[0];
      step();
      chk("status_phase", 32'(led_out[0]), 32'(v_ph));
      wr_reg(2'd2, 32'd0);
      step();
      bad = 0;
      for (int i = 0; i < 50; i++) begin
         if (led_out != 10'h001) bad++;
         step();
      end
      chk("half0_steady_errs", 32'(bad), 32'd0);

      // HALF_PERIOD write coincident with the tick that would toggle phase
      k = 0;
      while (readdata[9:8] != 2'b11 && k < 8) begin step(); k++; end
      chk("tick_align", 32'(readdata[9:8]), 32'd3);
      wr_reg(2'd2, 32'd3);
      repeat (11) step();
      chk("tick_align2", 32'(readdata[9:8]), 32'd3);
      wr_reg(2'd2, 32'd3);
      chk("hp_write_phase", 32'(readdata[0]), 32'd1);
      k = 0;
      while (readdata[0] && k < 20) begin step(); k++; end
      chk("hp_write_hold", 32'(k), 32'd12);

      // Asynchronous reset mid-blink
      wr_reg(2'd1, 32'd32);
      k = 0;
      while (readdata[0] && k < 40) begin step(); k++; end
      chk("phase0_reached", 32'(readdata[0]), 32'd0);
      #2;
      reset_n = 1'b0;
      #1;
      model_reset();
      chk("async_reset_led", 32'(led_out), 32'd0);
      foreach (rv[i]) begin
         address = rv[i].a; #1;
         chk("async_reset_read", readdata, rv[i].exp);
      end
      led_in = 10'h2AA;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      address = 2'd3;
      step();
      chk("post_reset_passthru", 32'(led_out), 32'h2AA);

      // Random traffic against the model
      for (int i = 0; i < 3000; i++) begin
         led_in = LW'($urandom);
         if ($urandom_range(0, 9) < 2) begin
            logic [1:0]  a = 2'($urandom_range(0, 3));
            logic [31:0] d = $urandom;
            if (a == 2'd2) d[15:0] = 16'($urandom_range(0, 4));
            wr_reg(a, d);
         end else begin
            address = 2'($urandom_range(0, 3));
            step();
         end
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/ledr_pwm_driver.md
Name: ledr_pwm_driver

Overview:
- Sits directly downstream of the 10-bit LEDR output PIO, between the PIO's out_port and the board LEDR pins.
- Adds global PWM brightness and optional blinking to the LED pattern the CPU writes.
- Control registers sit on their own Avalon-MM slave on the same Nios II system clock.

Parameters:
- LED_WIDTH, 10, width of led_in/led_out.
- PRESCALE, 50000, system clocks per blink tick (1 ms at 50 MHz); minimum 1.

Ports:
- clk  input  1  system clock.
- reset_n  input  1  asynchronous active-low reset.
- led_in  input  LED_WIDTH  LED pattern from upstream PIO out_port.
- address  input  2  Avalon register select.
- chipselect  input  1  Avalon slave select.
- write_n  input  1  Avalon write strobe, active-low.
- writedata  input  32  Avalon write data.
- readdata  output  32  Avalon read data, combinational, zero-extended, zero-wait.
- led_out  output  LED_WIDTH  registered drive to LEDR pins.

Behaviour:
- One clock (clk); reset is asynchronous, active-low (reset_n). All state clears immediately on assertion, regardless of clk.
- Register map. A write occurs when chipselect & ~write_n. Reads never have side effects.
  - addr0 CTRL [1:0]: bit0 enable, bit1 blink_en.
  - addr1 DUTY [7:0].
  - addr2 HALF_PERIOD [15:0]: blink half-period, in ticks.
  - addr3 STATUS: read-only; bit0 = blink phase, bits[15:8] = pwm_cnt; writes ignored.
  - Unused readdata bits read 0.
- Reset values:
  - CTRL = 0; DUTY = 8'hFF; duty_active = 8'hFF; HALF_PERIOD = 16'd500.
  - pwm_cnt = 0; prescaler = 0; blink_cnt = 0; phase = 1.
  - led_out = 0.
- PWM:
  - pwm_cnt is 8 bits, increments every clk, wraps 255->0.
  - duty_active loads from DUTY only on the cycle pwm_cnt == 255.
  - If a DUTY write lands in that same cycle, duty_active takes the pre-write DUTY. The new value applies at the following wrap.
  - pwm_on = (duty_active == 8'hFF) | (pwm_cnt < duty_active).
  - Duty 0 gives always off; 255 gives always on; otherwise high for exactly duty_active of every 256 clocks.
- Prescaler:
  - Counts 0..PRESCALE-1 continuously.
  - tick pulses for one clock when the count equals PRESCALE-1, then the count wraps to 0.
- Blink:
  - If blink_en = 0 or HALF_PERIOD = 0: phase is forced to 1 and blink_cnt is held at 0.
  - Otherwise, on each tick:
    - If blink_cnt == HALF_PERIOD-1: toggle phase and clear blink_cnt.
    - Else: blink_cnt += 1.
  - A HALF_PERIOD write clears blink_cnt and sets phase = 1 on the next clock, taking priority over a coincident tick. The prescaler is unaffected.
  - A CTRL write that clears blink_en forces phase = 1 from the next clock.
- Output:
  - led_out <= enable ? (led_in & {LED_WIDTH{pwm_on & phase}}) : led_in.
  - Latency from led_in or pwm_on to led_out is 1 clock.
  - With enable = 0 the block is a 1-cycle registered passthrough; the PWM and blink counters keep running.
- Counters are free-running; no overflow beyond the wrap rules above.
- Reset mid-operation: every output and all state return to the reset values asynchronously. After release, operation resumes from pwm_cnt = 0 and prescaler = 0.

Test Plan:
- Reset then idle, led_in = 10'h3FF, CTRL = 0 -> led_out = 0 during reset, then 10'h3FF one clock after release. readdata at addr1 = 0x000000FF; at addr2 = 0x000001F4.
- CTRL = 1, DUTY = 64, led_in = 10'h155 -> after the next pwm_cnt wrap, led_out = 10'h155 for 64 clocks and 0 for 192 clocks, repeating. Check 4 consecutive 256-clock windows.
- DUTY = 0, then DUTY = 255 -> led_out held 0 for a full 256-clock window, then held equal to led_in for a full window. A DUTY write at pwm_cnt == 255 takes effect one window later.
- PRESCALE = 4, CTRL = 3, DUTY = 255, HALF_PERIOD = 3, led_in = 10'h001 -> led_out toggles every 12 clocks. STATUS bit0 tracks phase. A HALF_PERIOD = 0 write forces led_out = 10'h001 steady.
- HALF_PERIOD write coincident with a tick -> blink_cnt = 0 and phase = 1 on the next clock. No toggle occurs from that tick.
- Assert reset_n mid-blink (phase 0, DUTY = 32) asynchronously between clk edges -> led_out = 0 and all registers at reset values immediately. Release -> passthrough behaviour resumes.
